spi_slave_01: RTL and testbench

SPI slave (responder) for CPOL=0 / CPHA=1 links: sclk idles low, each bit is launched on the sclk rising edge and sampled on the falling edge, MSB first, 8-bit words. It is the far end of our SPI master. It oversamples the link pins on the local system clock and presents received bytes and transmit-byte requests to fabric logic through single-cycle strobes. It handles back-to-back bytes within one select window and aborts cleanly on early deselect.

---
 rtl/spi_slave_01.sv | 138 +++++++++++++
 tb/tb_spi_slave_01.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_01.sv
// SPI responder for CPOL=0 / CPHA=1 links, 8-bit MSB-first words.
// Link pins are oversampled on clk; fabric sees single-cycle rx/tx/abort strobes.
module spi_slave_01 (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss,
   input  logic       sclk,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] tx_data,
   output logic       tx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       abort,
   output logic       busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   // Synchroniser and edge-detect stages for the asynchronous link pins.
   logic ss_meta,   ss_sync,   ss_prev;
   logic sclk_meta, sclk_sync, sclk_prev;
   logic mosi_meta, mosi_sync;

   // Frame state.
   logic [0:0] state;
   logic [7:0] tx_shift;
   logic [7:0] rx_shift;
   logic [2:0] bit_ctr;
   logic       partial;

   logic       rise;
   logic       fall;
   logic       sel;
   logic       desel;
   logic       boundary;
   logic [7:0] rx_next;

   // ss resets to its deselected level so a tied-low ss yields a clean sel.
   // NOTE: every register here uses <= so all flops update from the
   // pre-edge values, modelling real hardware instead of evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_meta   <= 1'b1;
         ss_sync   <= 1'b1;
         ss_prev   <= 1'b1;
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         ss_meta   <= ss;
         ss_sync   <= ss_meta;
         ss_prev   <= ss_sync;
         sclk_meta <= sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         mosi_meta <= mosi;
         mosi_sync <= mosi_meta;
      end
   end

   assign rise     = sclk_sync & ~sclk_prev;
   assign fall     = ~sclk_sync & sclk_prev;
   assign sel      = ~ss_sync & ss_prev;
   assign desel    = ss_sync & ~ss_prev;
   assign boundary = fall && (bit_ctr == 3'd7);
   assign rx_next  = {rx_shift[6:0], mosi_sync};

   assign busy = (state == SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx_shift <= 8'h00;
         rx_shift <= 8'h00;
         bit_ctr  <= 3'd0;
         partial  <= 1'b0;
         miso     <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_ack   <= 1'b0;
         abort    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_ack   <= 1'b0;
         abort    <= 1'b0;

         case (state)
            IDLE: begin
               if (sel) begin
                  state    <= SHIFT;
                  tx_shift <= tx_data;
                  tx_ack   <= 1'b1;
                  bit_ctr  <= 3'd0;
                  partial  <= 1'b0;
                  miso     <= tx_data[7];
               end
            end

            SHIFT: begin
               if (fall) begin
                  rx_shift <= rx_next;
                  bit_ctr  <= bit_ctr + 3'd1;
               end

               // A deselect on the byte-completing edge still delivers the
               // byte, but suppresses both the abort and the tx reload.
               if (desel) begin
                  state <= IDLE;
                  miso  <= 1'b0;
                  if (boundary) begin
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
                  end else if (partial || (bit_ctr != 3'd0)) begin
                     abort <= 1'b1;
                  end
               end else if (rise) begin
                  miso     <= tx_shift[7];
                  tx_shift <= {tx_shift[6:0], 1'b0};
                  partial  <= 1'b1;
               end else if (boundary) begin
                  rx_data  <= rx_next;
                  rx_valid <= 1'b1;
                  tx_shift <= tx_data;
                  tx_ack   <= 1'b1;
                  partial  <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_01.sv
// Bench for spi_slave_01: a behavioural SPI master (half period 4 clk) plus
// a fabric model feeding tx_data from a per-frame table and logging strobes.
module tb_spi_slave_01;

   logic       clk = 1'b0;
   logic       rst;
   logic       ss;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       abort;
   logic       busy;

   int total = 0;
   int bad   = 0;

   // Written only by the fabric/monitor process.
   int         ack_cnt   = 0;
   int         rx_cnt    = 0;
   int         abort_cnt = 0;
   int         wide_cnt  = 0;
   logic [7:0] rx_log [0:255];

   // Written only by the main process.
   logic [7:0] tx_tab [0:15];
   int         ack_base = 0;
   logic [7:0] mo_buf [0:3];
   logic [7:0] mi_buf [0:3];

   spi_slave_01 dut (
      .clk      (clk),
      .rst      (rst),
      .ss       (ss),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso),
      .tx_data  (tx_data),
      .tx_ack   (tx_ack),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .abort    (abort),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Fabric: presents tx_tab[n] after the n-th tx_ack of the current frame.
   initial begin : fabric
      logic prev_rv, prev_ta, prev_ab;
      logic [3:0] idx;
      prev_rv = 1'b0;
      prev_ta = 1'b0;
      prev_ab = 1'b0;
      forever begin
         @(negedge clk);
         if ((rx_valid === 1'b1 && prev_rv) || (tx_ack === 1'b1 && prev_ta) ||
             (abort === 1'b1 && prev_ab))
            wide_cnt++;
         prev_rv = (rx_valid === 1'b1);
         prev_ta = (tx_ack === 1'b1);
         prev_ab = (abort === 1'b1);
         if (rx_valid === 1'b1) begin
            rx_log[8'(rx_cnt)] = rx_data;
            rx_cnt++;
         end
         if (tx_ack === 1'b1) ack_cnt++;
         if (abort === 1'b1) abort_cnt++;
         idx = 4'(ack_cnt - ack_base);
         tx_data = tx_tab[idx];
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One CPOL=0/CPHA=1 byte (or its first nbits); bits launched on the rise,
   // miso sampled at the end of the high phase. Optionally deselects on the
   // final falling edge.
   task automatic spi_byte(input logic [7:0] mo, input int nbits,
                           input bit desel_last, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         mosi = mo[7-i];
         cyc(4);
         mi[7-i] = miso;
         if (desel_last && i == nbits - 1) ss = 1'b1;
         sclk = 1'b0;
         cyc(4);
      end
   endtask

   task automatic start_frame();
      ack_base = ack_cnt;
      cyc(2);
      ss = 1'b0;
      cyc(4);
   endtask

   task automatic send_frame(input int n);
      logic [7:0] got;
      start_frame();
      for (int b = 0; b < n; b++) begin
         spi_byte(mo_buf[b], 8, 1'b0, got);
         mi_buf[b] = got;
      end
      cyc(4);
      ss = 1'b1;
      cyc(6);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", miso); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      total++; if (tx_ack !== 1'b0) begin bad++; $display("FAIL reset_tx_ack: got %b want 0", tx_ack); end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort: got %b want 0", abort); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      cyc(6);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
      total++; if (ack_cnt !== 0) begin bad++; $display("FAIL idle_tx_ack_count: got %0d want 0", ack_cnt); end
   endtask

   task automatic test_single_byte();
      int r0, a0, b0;
      logic [7:0] got;
      r0 = rx_cnt; a0 = ack_cnt; b0 = abort_cnt;
      for (int i = 0; i < 4; i++) tx_tab[i] = 8'h3C;
      start_frame();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
      spi_byte(8'hA5, 8, 1'b0, got);
      cyc(4);
      ss = 1'b1;
      cyc(6);
      total++; if (rx_cnt - r0 !== 1) begin bad++; $display("FAIL single_rx_count: got %0d want 1", rx_cnt - r0); end
      total++; if (rx_log[8'(r0)] !== 8'hA5) begin bad++; $display("FAIL single_rx_data: got %h want a5", rx_log[8'(r0)]); end
      total++; if (got !== 8'h3C) begin bad++; $display("FAIL single_miso_byte: got %h want 3c", got); end
      total++; if (ack_cnt - a0 !== 2) begin bad++; $display("FAIL single_tx_ack_count: got %0d want 2", ack_cnt - a0); end
      total++; if (abort_cnt - b0 !== 0) begin bad++; $display("FAIL single_abort: got %0d want 0", abort_cnt - b0); end
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL single_miso_idle: got %b want 0", miso); end
   endtask

   task automatic test_back_to_back();
      int r0, a0, b0;
      logic [7:0] exp_tx [0:2];
      exp_tx[0] = 8'h11; exp_tx[1] = 8'h22; exp_tx[2] = 8'h33;
      mo_buf[0] = 8'h01; mo_buf[1] = 8'h80; mo_buf[2] = 8'hFF;
      for (int i = 0; i < 3; i++) tx_tab[i] = exp_tx[i];
      tx_tab[3] = 8'h00;
      r0 = rx_cnt; a0 = ack_cnt; b0 = abort_cnt;
      send_frame(3);
      total++; if (rx_cnt - r0 !== 3) begin bad++; $display("FAIL b2b_rx_count: got %0d want 3", rx_cnt - r0); end
      for (int i = 0; i < 3; i++) begin
         total++; if (rx_log[8'(r0 + i)] !== mo_buf[i]) begin bad++; $display("FAIL b2b_rx_%0d: got %h want %h", i, rx_log[8'(r0 + i)], mo_buf[i]); end
         total++; if (mi_buf[i] !== exp_tx[i]) begin bad++; $display("FAIL b2b_miso_%0d: got %h want %h", i, mi_buf[i], exp_tx[i]); end
      end
      total++; if (ack_cnt - a0 !== 4) begin bad++; $display("FAIL b2b_tx_ack_count: got %0d want 4", ack_cnt - a0); end
      total++; if (abort_cnt - b0 !== 0) begin bad++; $display("FAIL b2b_abort: got %0d want 0", abort_cnt - b0); end
   endtask

   task automatic test_abort();
      int r0, b0;
      logic [7:0] got, held, t0;
      held = rx_data;
      r0 = rx_cnt; b0 = abort_cnt;
      tx_tab[0] = 8'hFF; tx_tab[1] = 8'h00;
      start_frame();
      spi_byte(8'hE7, 5, 1'b0, got);
      ss = 1'b1;
      cyc(3);
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL abort_miso: got %b want 0", miso); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      cyc(4);
      total++; if (abort_cnt - b0 !== 1) begin bad++; $display("FAIL abort_count: got %0d want 1", abort_cnt - b0); end
      total++; if (rx_cnt - r0 !== 0) begin bad++; $display("FAIL abort_rx_count: got %0d want 0", rx_cnt - r0); end
      total++; if (rx_data !== held) begin bad++; $display("FAIL abort_rx_hold: got %h want %h", rx_data, held); end
      t0 = 8'($urandom);
      tx_tab[0] = t0; tx_tab[1] = 8'h00;
      mo_buf[0] = 8'h5A;
      r0 = rx_cnt;
      send_frame(1);
      total++; if (rx_log[8'(r0)] !== 8'h5A || rx_cnt - r0 !== 1) begin bad++; $display("FAIL abort_next_rx: got %h (n=%0d) want 5a", rx_log[8'(r0)], rx_cnt - r0); end
      total++; if (mi_buf[0] !== t0) begin bad++; $display("FAIL abort_next_miso: got %h want %h", mi_buf[0], t0); end
   endtask

   task automatic test_boundary_deselect();
      int r0, a0, b0;
      logic [7:0] got;
      r0 = rx_cnt; a0 = ack_cnt; b0 = abort_cnt;
      tx_tab[0] = 8'hC0; tx_tab[1] = 8'h00;
      start_frame();
      spi_byte(8'h69, 8, 1'b1, got);
      cyc(6);
      total++; if (rx_cnt - r0 !== 1) begin bad++; $display("FAIL bdesel_rx_count: got %0d want 1", rx_cnt - r0); end
      total++; if (rx_data !== 8'h69) begin bad++; $display("FAIL bdesel_rx_data: got %h want 69", rx_data); end
      total++; if (abort_cnt - b0 !== 0) begin bad++; $display("FAIL bdesel_abort: got %0d want 0", abort_cnt - b0); end
      total++; if (ack_cnt - a0 !== 1) begin bad++; $display("FAIL bdesel_tx_ack_count: got %0d want 1", ack_cnt - a0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bdesel_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_byte();
      int r0;
      logic [7:0] got;
      tx_tab[0] = 8'hFF; tx_tab[1] = 8'hFF;
      start_frame();
      spi_byte(8'hF0, 4, 1'b0, got);
      rst = 1'b1;
      #1;
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso: got %b want 0", miso); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      total++; if ({rx_valid, tx_ack, abort} !== 3'b000) begin bad++; $display("FAIL rstmid_strobes: got %b want 000", {rx_valid, tx_ack, abort}); end
      ss = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(4);
      tx_tab[0] = 8'h96; tx_tab[1] = 8'h00;
      mo_buf[0] = 8'hC3;
      r0 = rx_cnt;
      send_frame(1);
      total++; if (rx_log[8'(r0)] !== 8'hC3 || rx_cnt - r0 !== 1) begin bad++; $display("FAIL rstmid_rx: got %h (n=%0d) want c3", rx_log[8'(r0)], rx_cnt - r0); end
      total++; if (mi_buf[0] !== 8'h96) begin bad++; $display("FAIL rstmid_miso_byte: got %h want 96", mi_buf[0]); end
   endtask

   // Reference model: a frame of n bytes yields exactly the mosi bytes on
   // rx_data, returns tx_tab[0..n-1] on miso and takes n+1 tx_data captures.
   task automatic test_random();
      int n, r0, a0, b0;
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 3);
         for (int b = 0; b < n; b++) begin
            mo_buf[b] = 8'($urandom);
            tx_tab[b] = 8'($urandom);
         end
         tx_tab[n] = 8'h00;
         r0 = rx_cnt; a0 = ack_cnt; b0 = abort_cnt;
         send_frame(n);
         total++; if (rx_cnt - r0 !== n) begin bad++; $display("FAIL rand%0d_rx_count: got %0d want %0d", f, rx_cnt - r0, n); end
         for (int b = 0; b < n; b++) begin
            total++; if (rx_log[8'(r0 + b)] !== mo_buf[b]) begin bad++; $display("FAIL rand%0d_rx_%0d: got %h want %h", f, b, rx_log[8'(r0 + b)], mo_buf[b]); end
            total++; if (mi_buf[b] !== tx_tab[b]) begin bad++; $display("FAIL rand%0d_miso_%0d: got %h want %h", f, b, mi_buf[b], tx_tab[b]); end
         end
         total++; if (ack_cnt - a0 !== n + 1) begin bad++; $display("FAIL rand%0d_tx_ack_count: got %0d want %0d", f, ack_cnt - a0, n + 1); end
         total++; if (abort_cnt - b0 !== 0) begin bad++; $display("FAIL rand%0d_abort: got %0d want 0", f, abort_cnt - b0); end
      end
   endtask

   task automatic test_tied_low();
      int r0;
      logic [7:0] got, t0;
      t0 = 8'($urandom);
      rst = 1'b1;
      ss = 1'b0;
      sclk = 1'b0;
      tx_tab[0] = t0; tx_tab[1] = 8'h00;
      ack_base = ack_cnt;
      r0 = rx_cnt;
      cyc(3);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      total++; if (tx_ack !== 1'b0) begin bad++; $display("FAIL tied_tx_ack_early: got %b want 0", tx_ack); end
      @(posedge clk); @(negedge clk);
      total++; if (tx_ack !== 1'b1) begin bad++; $display("FAIL tied_tx_ack_3cyc: got %b want 1", tx_ack); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL tied_busy: got %b want 1", busy); end
      cyc(3);
      spi_byte(8'h7E, 8, 1'b0, got);
      cyc(4);
      total++; if (rx_cnt - r0 !== 1 || rx_data !== 8'h7E) begin bad++; $display("FAIL tied_rx: got %h (n=%0d) want 7e", rx_data, rx_cnt - r0); end
      total++; if (got !== t0) begin bad++; $display("FAIL tied_miso_byte: got %h want %h", got, t0); end
      ss = 1'b1;
      cyc(6);
   endtask

   task automatic test_strobes();
      total++; if (wide_cnt !== 0) begin bad++; $display("FAIL strobe_width: got %0d wide pulses want 0", wide_cnt); end
   endtask

   initial begin
      rst  = 1'b1;
      ss   = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      for (int i = 0; i < 16; i++) tx_tab[i] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         mo_buf[i] = 8'h00;
         mi_buf[i] = 8'h00;
      end
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_abort();
      test_boundary_deselect();
      test_reset_mid_byte();
      test_random();
      test_tied_low();
      test_strobes();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
